// File: rtl/uart_rx.sv
// 8O1 UART receiver: 2-flop synchroniser, mid-bit sampling, valid/ack holding register.
// Ports: clock, reset (async low), rx in; data/data_valid/parity_error/frame_error/overrun/busy out; read_ack in.
module uart_rx #(
  parameter int CLOCK_FREQ = 12_000_000,
  parameter int BAUD_RATE  = 115_200
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] data,
  output logic       data_valid,
  input  logic       read_ack,
  output logic       parity_error,
  output logic       frame_error,
  output logic       overrun,
  output logic       busy
);

  localparam int CPB  = CLOCK_FREQ / BAUD_RATE;
  localparam int HALF = CPB / 2;
  localparam int CW   = (CPB > 2) ? $clog2(CPB) : 1;

  localparam logic [CW-1:0] CNT_FULL = CW'(CPB - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(HALF - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    WAIT_IDLE
  } state_t;

  state_t        state;
  logic          rx_m;
  logic          rx_s;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;
  logic          parity_acc;
  logic          perr;

  assign busy = (state != IDLE);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rx_m         <= 1'b1;
      rx_s         <= 1'b1;
      state        <= IDLE;
      cnt          <= '0;
      bit_idx      <= '0;
      shift        <= '0;
      parity_acc   <= 1'b1;
      perr         <= 1'b0;
      data         <= '0;
      data_valid   <= 1'b0;
      parity_error <= 1'b0;
      frame_error  <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;

      if (read_ack && data_valid) begin
        data_valid <= 1'b0;
        overrun    <= 1'b0;
      end

      unique case (state)
        IDLE: begin
          if (!rx_s) begin
            cnt   <= CNT_HALF;
            state <= START;
          end
        end
        START: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else if (rx_s) begin
            state <= IDLE;
          end else begin
            cnt        <= CNT_FULL;
            bit_idx    <= '0;
            parity_acc <= 1'b1;
            state      <= DATA;
          end
        end
        DATA: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            shift[bit_idx] <= rx_s;
            parity_acc     <= parity_acc ^ rx_s;
            cnt            <= CNT_FULL;
            bit_idx        <= bit_idx + 1'b1;
            if (bit_idx == 3'd7) state <= PARITY;
          end
        end
        PARITY: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            perr  <= (rx_s != parity_acc);
            cnt   <= CNT_FULL;
            state <= STOP;
          end
        end
        STOP: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            // An ack in this same cycle frees the register for the new byte.
            if (!data_valid || read_ack) begin
              data         <= shift;
              parity_error <= perr;
              frame_error  <= ~rx_s;
              data_valid   <= 1'b1;
            end else begin
              overrun <= 1'b1;
            end
            state <= rx_s ? IDLE : WAIT_IDLE;
          end
        end
        WAIT_IDLE: begin
          if (rx_s) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: random and directed 8O1 frames
// checked against a behavioural frame model.
module tb_uart_rx;

  localparam int CPB  = 12_000_000 / 115_200;
  localparam int HALF = CPB / 2;
  localparam int LAT  = 2 + HALF + 10 * CPB + 1;

  logic       clock;
  logic       reset;
  logic       rx;
  logic [7:0] data;
  logic       data_valid;
  logic       read_ack;
  logic       parity_error;
  logic       frame_error;
  logic       overrun;
  logic       busy;

  uart_rx dut (
    .clock        (clock),
    .reset        (reset),
    .rx           (rx),
    .data         (data),
    .data_valid   (data_valid),
    .read_ack     (read_ack),
    .parity_error (parity_error),
    .frame_error  (frame_error),
    .overrun      (overrun),
    .busy         (busy)
  );

  typedef struct {
    logic [7:0] d;
    logic       pe;
    logic       fe;
    int         t0;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;
  logic dv_q  = 1'b0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every new byte presented is compared with the oldest expectation.
  always @(negedge clock) begin
    if (data_valid && !dv_q) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_byte: got %0h expected none", data);
      end else begin
        exp_t e;
        int   lat;
        e   = sb.pop_front();
        lat = cyc - e.t0;
        check("data", {24'd0, data}, {24'd0, e.d});
        check("parity_error", {31'd0, parity_error}, {31'd0, e.pe});
        check("frame_error", {31'd0, frame_error}, {31'd0, e.fe});
        tests++;
        if (lat < LAT - 1 || lat > LAT + 1) begin
          fails++;
          $display("FAIL latency: got %0d expected %0d+-1", lat, LAT);
        end
      end
    end
    dv_q = data_valid;
  end

  // Called at a negedge; drives one full frame, one bit per CPB clocks.
  task automatic send_frame(input logic [7:0] d,
                            input logic par,
                            input logic stp,
                            input bit push);
    exp_t e;
    e.d  = d;
    e.pe = (par != ~^d);
    e.fe = ~stp;
    e.t0 = cyc + 1;
    if (push) sb.push_back(e);
    rx = 1'b0;
    repeat (CPB) @(negedge clock);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      repeat (CPB) @(negedge clock);
    end
    rx = par;
    repeat (CPB) @(negedge clock);
    rx = stp;
    repeat (CPB) @(negedge clock);
  endtask

  task automatic wait_valid(input int budget);
    int n = 0;
    while (!data_valid && n < budget) begin
      @(negedge clock);
      n++;
    end
    check("valid_seen", {31'd0, data_valid}, 32'd1);
  endtask

  task automatic ack();
    read_ack = 1'b1;
    @(negedge clock);
    read_ack = 1'b0;
    check("ack_clears", {31'd0, data_valid}, 32'd0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] d;
    logic       par;
    logic       stp;

    reset    = 1'b0;
    rx       = 1'b1;
    read_ack = 1'b0;
    repeat (3) @(negedge clock);
    check("rst_data", {24'd0, data}, 32'd0);
    check("rst_valid", {31'd0, data_valid}, 32'd0);
    check("rst_pe", {31'd0, parity_error}, 32'd0);
    check("rst_fe", {31'd0, frame_error}, 32'd0);
    check("rst_ovr", {31'd0, overrun}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    reset = 1'b1;
    repeat (5) @(negedge clock);

    // Clean byte
    send_frame(8'hA5, 1'b1, 1'b1, 1);
    wait_valid(2 * CPB);
    ack();
    repeat (10) @(negedge clock);

    // Wrong parity, then correct parity
    send_frame(8'h01, 1'b1, 1'b1, 1);
    wait_valid(2 * CPB);
    ack();
    repeat (10) @(negedge clock);
    send_frame(8'h00, 1'b1, 1'b1, 1);
    wait_valid(2 * CPB);
    ack();
    repeat (10) @(negedge clock);

    // Framing error followed by a long break
    send_frame(8'h3C, 1'b1, 1'b0, 1);
    wait_valid(2 * CPB);
    ack();
    repeat (3000 - CPB) @(negedge clock);
    check("break_busy", {31'd0, busy}, 32'd1);
    rx = 1'b1;
    repeat (3 * CPB) @(negedge clock);
    check("break_idle", {31'd0, busy}, 32'd0);
    check("break_no_byte", {31'd0, data_valid}, 32'd0);

    // Short glitch is rejected
    rx = 1'b0;
    repeat (20) @(negedge clock);
    rx = 1'b1;
    repeat (HALF + 3) @(negedge clock);
    check("glitch_busy", {31'd0, busy}, 32'd0);
    check("glitch_valid", {31'd0, data_valid}, 32'd0);
    send_frame(8'h55, 1'b1, 1'b1, 1);
    wait_valid(2 * CPB);
    ack();
    repeat (10) @(negedge clock);

    // Back-to-back without ack: second byte dropped
    send_frame(8'h11, 1'b1, 1'b1, 1);
    send_frame(8'h22, 1'b1, 1'b1, 0);
    repeat (5) @(negedge clock);
    check("ovr_set", {31'd0, overrun}, 32'd1);
    check("ovr_data", {24'd0, data}, 32'h11);
    check("ovr_valid", {31'd0, data_valid}, 32'd1);
    ack();
    check("ovr_clear", {31'd0, overrun}, 32'd0);
    repeat (10) @(negedge clock);

    // Reset in the middle of bit 4 of 0xFF
    rx = 1'b0;
    repeat (CPB) @(negedge clock);
    rx = 1'b1;
    repeat (4 * CPB + HALF) @(negedge clock);
    reset = 1'b0;
    repeat (3) @(negedge clock);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_data", {24'd0, data}, 32'd0);
    reset = 1'b1;
    repeat (7 * CPB) @(negedge clock);
    check("abort_no_byte", {31'd0, data_valid}, 32'd0);
    send_frame(8'h7E, 1'b1, 1'b1, 1);
    wait_valid(2 * CPB);
    ack();
    repeat (10) @(negedge clock);

    // Random frames
    for (int k = 0; k < 16; k++) begin
      d   = 8'($urandom);
      par = (~^d) ^ ($urandom_range(0, 3) == 0);
      stp = ($urandom_range(0, 4) != 0);
      send_frame(d, par, stp, 1);
      wait_valid(2 * CPB);
      ack();
      if (!stp) begin
        repeat ($urandom_range(100, 400)) @(negedge clock);
        rx = 1'b1;
        repeat (2 * CPB) @(negedge clock);
      end
      repeat ($urandom_range(1, 30)) @(negedge clock);
    end

    check("sb_empty", sb.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
